uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Synthesizable 8N1 UART transmitter with a byte FIFO front-end. It drives the SoC console line `RsTx` that the bench terminal decodes.
- Sits between the APB/AHB UART register slave, which pushes bytes, and the pad/terminal, which consumes the serial bit stream.
- Bit time is runtime-programmable. `prescale = 15` at a 10 ns HCLK gives 160 ns per bit, matching the bench terminal.

Parameters:
- `DEPTH`, 16: FIFO entries; must be a power of 2, minimum 2.
- `AW`, 4: log2(`DEPTH`); pointer width.

Ports:
- `HCLK`  input  1  system clock; all logic on the rising edge.
- `HRESETn`  input  1  asynchronous active-low reset.
- `en`  input  1  transmitter enable; gates the start of new frames.
- `prescale`  input  16  clocks per bit minus 1.
- `wdata`  input  8  byte to enqueue.
- `wr`  input  1  enqueue strobe, one byte per cycle.
- `ovf_clr`  input  1  clears the sticky overflow flag.
- `full`  output  1  FIFO holds `DEPTH` bytes.
- `empty`  output  1  FIFO holds 0 bytes.
- `level`  output  AW+1  current FIFO occupancy.
- `ovf`  output  1  sticky flag: a write was dropped.
- `busy`  output  1  a frame is in progress.
- `tx`  output  1  serial out; idles high.

Behaviour:
- Reset (`HRESETn` low, async): pointers and `level` = 0, `empty` = 1, `full` = 0, `ovf` = 0, `busy` = 0, `tx` = 1, FSM = IDLE, counters = 0.
  - Takes effect immediately, including mid-frame.
  - The partially sent byte is lost; FIFO contents are discarded.
- FIFO
  - A write is accepted when `wr` = 1 and `full` = 0.
  - `wr` while `full` = 1 drops the byte and sets `ovf` = 1 on the next edge. This holds even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop: `level` unchanged.
  - Pointers wrap modulo `DEPTH`.
  - `full`, `empty` and `level` are registered and update on the edge after the event.
  - `ovf_clr` clears `ovf`. If `ovf_clr` and an overflow occur in the same cycle, set wins.
- Baud counter
  - Loads `prescale` on entry to each bit and decrements to 0.
  - Each bit lasts exactly `prescale`+1 cycles; `prescale` = 0 gives 1 cycle per bit.
  - `prescale` is sampled at each bit start; changes mid-bit take effect at the next bit.
- FSM states: IDLE, START, DATA, STOP.
- IDLE
  - `tx` = 1, `busy` = 0.
  - If `en` = 1 and `empty` = 0: pop the head into the shift register, go to START, `busy` = 1.
- START: `tx` = 0 for one bit time, then go to DATA with bit index 0.
- DATA
  - `tx` = shift[0]; data is sent LSB first.
  - Shift right at each bit end; 8 bits, index 0..7; go to STOP after bit 7.
- STOP
  - `tx` = 1 for one bit time.
  - At the end of the bit: if `en` = 1 and `empty` = 0, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Latency: `wr` sampled at edge k into an empty FIFO with FSM idle and `en` = 1:
  - `empty` falls after edge k.
  - Pop and START occur at edge k+1; `tx` falls after edge k+1.
- A frame spans exactly 10×(`prescale`+1) cycles.
- `en` deasserted mid-frame: the current frame completes normally, then the FSM holds in IDLE. Queued bytes are retained.
- `tx` is a registered output with no combinational path from inputs.

Test Plan:
- Single byte: `prescale` = 15, `en` = 1, write 0x55 → `tx` falls 2 edges after `wr`. Pattern is 0,1,0,1,0,1,0,1,0,1, each 16 cycles. Bench terminal prints "U". `busy` is high for 160 cycles.
- Back-to-back: write "Hi" (0x48, 0x69) on consecutive cycles → `level` goes 1, then 2. Frames are contiguous: second start bit immediately follows the first stop bit. Terminal prints "Hi". `empty` = 1 after the second pop.
- Overflow: `en` = 0, write 17 bytes 0x00..0x10 → `full` = 1 and `level` = 16 after byte 16. `ovf` = 1 after byte 17. Set `en` = 1 → bytes 0x00..0x0F are sent and 0x10 is never sent. Pulse `ovf_clr` → `ovf` = 0.
- Enable drop: start 0xA3, drop `en` during DATA bit 3 with 0x5C queued → 0xA3 frame completes and `tx` stays 1. `level` = 1 until `en` is re-raised, then 0x5C is sent.
- Reset mid-frame: assert `HRESETn` = 0 during DATA of 0xFF → `tx` = 1 asynchronously, `level` = 0, `busy` = 0. After release, `tx` stays high with no spurious frame.
- Min prescale: `prescale` = 0, write 0x0F → 10-cycle frame with bits 0,1,1,1,1,0,0,0,0,1.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter with a byte FIFO front-end.
// Bytes pushed with wr are sent LSB first, framed by one start bit (0)
// and one stop bit (1). Each bit lasts prescale+1 HCLK cycles.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          en,
  input  logic [15:0]   prescale,
  input  logic [7:0]    wdata,
  input  logic          wr,
  input  logic          ovf_clr,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          busy,
  output logic          tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   level_n;
  logic          push, pop;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          bit_end;

  // A write is accepted only while there is room; a pop never blocks it.
  assign push = wr && !full;

  // Storage array: no reset needed, contents are qualified by level.
  always_ff @(posedge HCLK) begin
    if (push) mem[wp] <= wdata;
  end

  // Occupancy after this cycle's push/pop; simultaneous push+pop cancels.
  always_comb begin
    level_n = level;
    case ({push, pop})
      2'b10:   level_n = level + 1'b1;
      2'b01:   level_n = level - 1'b1;
      default: level_n = level;
    endcase
  end

  // FIFO pointers, registered occupancy flags and sticky overflow.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      ovf   <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      level <= level_n;
      full  <= (level_n == FULL_LVL);
      empty <= (level_n == '0);
      // A dropped write wins over a clear in the same cycle.
      if (wr && full)   ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Transmit FSM state, baud counter, bit index, shifter and registered tx.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  assign bit_end = (cnt == '0);
  assign busy    = (state != IDLE);

  // Next-state logic: prescale is loaded at every bit start, so a change
  // mid-bit only affects the following bit. STOP chains into START when
  // more data is queued, giving back-to-back frames with no idle gap.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop     = 1'b1;
          shift_n = mem[rp];
          cnt_n   = prescale;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = prescale;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n   = prescale;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (en && !empty) begin
            pop     = 1'b1;
            shift_n = mem[rp];
            cnt_n   = prescale;
            state_n = START;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level for the state being entered, so tx is a pure register.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule
